// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: registered immediate-extension stage between decode and the
// ID/EX operand mux. It widens an IN_W-bit immediate to OUT_W bits in one of four
// modes: sign, zero, upper (LUI) and branch offset (sign << 2). Transfers use a
// valid/ready handshake, and a synchronous flush drops every beat the stage holds.
//
// Build option: IMM_EXT_SKID_EN
//   defined   - two-entry (main + skid) buffer with a registered in_ready, so
//               there is no combinational path from out_ready to in_ready.
//   undefined - single register stage; in_ready = !out_valid || out_ready.
module imm_extend_pipe #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_imm,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data
);

   localparam int E = OUT_W - IN_W;

   localparam logic [1:0] MODE_SIGN   = 2'd0;
   localparam logic [1:0] MODE_ZERO   = 2'd1;
   localparam logic [1:0] MODE_UPPER  = 2'd2;
   localparam logic [1:0] MODE_BRANCH = 2'd3;

   logic [OUT_W-1:0] sext;
   logic [OUT_W-1:0] ext;
   logic             accept;
   logic             deliver;
   logic [OUT_W-1:0] main_data;

   // Extension is evaluated on the incoming beat; only the result is stored.
   always_comb begin
      sext = {{E{in_imm[IN_W-1]}}, in_imm};
      case (in_mode)
         MODE_SIGN:   ext = sext;
         MODE_ZERO:   ext = {{E{1'b0}}, in_imm};
         MODE_UPPER:  ext = {in_imm, {E{1'b0}}};
         MODE_BRANCH: ext = {sext[OUT_W-3:0], 2'b00};
         default:     ext = sext;
      endcase
   end

   assign accept   = in_valid && in_ready;
   assign deliver  = out_valid && out_ready;
   assign out_data = main_data;

`ifdef IMM_EXT_SKID_EN

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_FULL  = 2'd2;

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic             ready_q;
   logic [OUT_W-1:0] skid_data;
   logic             load_main_ext;
   logic             load_main_skid;
   logic             load_skid;

   assign in_ready  = ready_q;
   assign out_valid = (state != ST_EMPTY);

   // Occupancy transitions and the data moves that go with them.
   always_comb begin
      state_nxt      = state;
      load_main_ext  = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      case (state)
         ST_EMPTY: begin
            if (accept) begin
               state_nxt     = ST_ONE;
               load_main_ext = 1'b1;
            end
         end
         ST_ONE: begin
            if (accept && deliver) begin
               load_main_ext = 1'b1;
            end else if (deliver) begin
               state_nxt = ST_EMPTY;
            end else if (accept) begin
               state_nxt = ST_FULL;
               load_skid = 1'b1;
            end
         end
         ST_FULL: begin
            // in_ready is low here, so only a deliver can move the state.
            if (deliver) begin
               state_nxt      = ST_ONE;
               load_main_skid = 1'b1;
            end
         end
         default: state_nxt = ST_EMPTY;
      endcase
      // Flush drops both entries and the concurrent input beat, and leaves
      // out_data on its last value.
      if (flush) begin
         state_nxt      = ST_EMPTY;
         load_main_ext  = 1'b0;
         load_main_skid = 1'b0;
         load_skid      = 1'b0;
      end
   end

   // State and the registered in_ready, which is low only while both entries are full.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_EMPTY;
         ready_q <= 1'b1;
      end else begin
         state   <= state_nxt;
         ready_q <= (state_nxt != ST_FULL);
      end
   end

   // Main and skid data registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_data <= '0;
         skid_data <= '0;
      end else begin
         if (load_main_ext)       main_data <= ext;
         else if (load_main_skid) main_data <= skid_data;
         if (load_skid)           skid_data <= ext;
      end
   end

`else

   logic vld;

   assign in_ready  = !out_valid || out_ready;
   assign out_valid = vld;

   // Single register stage: an accept overwrites the entry (a simultaneous
   // deliver lets the new result replace the old); a lone deliver empties it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld       <= 1'b0;
         main_data <= '0;
      end else if (flush) begin
         vld <= 1'b0;
      end else if (accept) begin
         vld       <= 1'b1;
         main_data <= ext;
      end else if (deliver) begin
         vld <= 1'b0;
      end
   end

`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Scoreboard bench for imm_extend_pipe: the default 16->32 instance plus an 8->16
// instance. The driver pushes reference results on accept; negedge monitors pop
// and compare whenever the DUT presents a result.
module tb_imm_extend_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush, in_valid, in_ready, out_valid, out_ready;
   logic [15:0] in_imm;
   logic [1:0]  in_mode;
   logic [31:0] out_data;

   logic        flush2, in_valid2, in_ready2, out_valid2, out_ready2;
   logic [7:0]  in_imm2;
   logic [1:0]  in_mode2;
   logic [15:0] out_data2;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   logic [31:0] q[$];
   logic [15:0] q2[$];

`ifdef IMM_EXT_SKID_EN
   localparam int EXP_BP = 2;
`else
   localparam int EXP_BP = 1;
`endif

   always #5 clk = ~clk;

   imm_extend_pipe dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm), .in_mode(in_mode),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
   );

   imm_extend_pipe #(.IN_W(8), .OUT_W(16)) dut2 (
      .clk(clk), .rst_n(rst_n), .flush(flush2),
      .in_valid(in_valid2), .in_ready(in_ready2), .in_imm(in_imm2), .in_mode(in_mode2),
      .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2)
   );

   // Reference: integer value of the immediate, then scale and wrap to OUT_W.
   function automatic longint unsigned ref_ext(int iw, int ow, longint unsigned imm, int mode);
      longint            v;
      longint unsigned   mask;
      mask = (64'd1 << ow) - 64'd1;
      v    = longint'(imm);
      if (imm >= (64'd1 << (iw - 1))) v = v - longint'(64'd1 << iw);
      case (mode)
         0:       return longint'(v) & mask;
         1:       return imm;
         2:       return (imm * (64'd1 << (ow - iw))) & mask;
         default: return longint'(v * 4) & mask;
      endcase
   endfunction

   task automatic check(string name, longint unsigned act, longint unsigned exp);
      chk_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Monitor, main instance: presented data must match the head of the scoreboard.
   always @(negedge clk) begin
      if (rst_n) begin
         check("sb_valid", out_valid, q.size() != 0);
         if (out_valid && q.size() != 0) begin
            check("sb_data", out_data, q[0]);
            if (out_ready) void'(q.pop_front());
         end
         if (flush) q.delete();
         else if (in_valid && in_ready) q.push_back(32'(ref_ext(16, 32, in_imm, in_mode)));
      end
   end

   // Monitor, 8->16 instance.
   always @(negedge clk) begin
      if (rst_n) begin
         check("sb2_valid", out_valid2, q2.size() != 0);
         if (out_valid2 && q2.size() != 0) begin
            check("sb2_data", out_data2, q2[0]);
            if (out_ready2) void'(q2.pop_front());
         end
         if (flush2) q2.delete();
         else if (in_valid2 && in_ready2) q2.push_back(16'(ref_ext(8, 16, in_imm2, in_mode2)));
      end
   end

   initial begin
      logic [31:0] tp_exp [4];
      int          n_acc;
      int          idx;
      logic        acc;

      tp_exp = '{32'hFFFF8001, 32'h00008001, 32'h80010000, 32'hFFFE0004};
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_imm = '0; in_mode = '0; out_ready = 1'b1;
      flush2 = 1'b0; in_valid2 = 1'b0; in_imm2 = '0; in_mode2 = '0; out_ready2 = 1'b1;

      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_in_ready", in_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // 16'h8001 through all four modes back to back
      for (int m = 0; m < 4; m++) begin
         in_valid = 1'b1; in_imm = 16'h8001; in_mode = 2'(m);
         @(posedge clk); #1;
         check("tp_8001", out_data, tp_exp[m]);
         check("tp_8001_valid", out_valid, 1);
      end
      in_imm = 16'h7FFF; in_mode = 2'd0;
      @(posedge clk); #1;
      check("tp_7fff_sign", out_data, 32'h00007FFF);
      in_mode = 2'd3;
      @(posedge clk); #1;
      check("tp_7fff_branch", out_data, 32'h0001FFFC);
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Backpressure: stream 1,2,3 in zero mode with out_ready low
      out_ready = 1'b0; in_mode = 2'd1; idx = 1; n_acc = 0;
      in_valid = 1'b1; in_imm = 16'(idx);
      for (int c = 0; c < 6; c++) begin
         @(negedge clk); acc = in_ready;
         @(posedge clk); #1;
         if (acc) begin
            n_acc++; idx++;
            in_imm = 16'(idx);
            if (idx > 3) in_valid = 1'b0;
         end
      end
      check("bp_accepts", n_acc, EXP_BP);
      out_ready = 1'b1;
      for (int c = 0; c < 10 && idx <= 3; c++) begin
         @(negedge clk); acc = in_ready;
         @(posedge clk); #1;
         if (acc) begin
            idx++;
            in_imm = 16'(idx);
            if (idx > 3) in_valid = 1'b0;
         end
      end
      check("bp_all_sent", idx, 4);
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;

      // Flush with the stage filled and a concurrent input beat
      out_ready = 1'b0; in_valid = 1'b1; in_mode = 2'd1;
      for (int c = 0; c < 3; c++) begin
         in_imm = 16'h1110 + 16'(c);
         @(posedge clk); #1;
      end
      flush = 1'b1; in_imm = 16'hDEAD;
      @(posedge clk); #1;
      check("flush_full_valid", out_valid, 0);
      // Flush from empty: the beat accepted on the flush edge is discarded
      @(posedge clk); #1;
      check("flush_empty_valid", out_valid, 0);
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      // Asynchronous reset while a beat is held
      out_ready = 1'b0; in_valid = 1'b1; in_imm = 16'h4321; in_mode = 2'd0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("held_before_rst", out_valid, 1);
      #1;
      rst_n = 1'b0;
      q.delete();
      #1;
      check("async_rst_valid", out_valid, 0);
      check("async_rst_data", out_data, 0);
      check("async_rst_ready", in_ready, 1);
      @(negedge clk); #1;
      rst_n = 1'b1; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;

      // Randomized traffic; consumer held off on flush edges
      for (int c = 0; c < 400; c++) begin
         in_valid  = 1'($urandom_range(0, 1));
         in_imm    = 16'($urandom);
         in_mode   = 2'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 15) == 0);
         if (flush) out_ready = 1'b0;
         @(posedge clk); #1;
      end
      in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      check("drain_empty", q.size(), 0);

      // Narrow instance: 8 -> 16
      in_valid2 = 1'b1; in_imm2 = 8'h80; in_mode2 = 2'd0;
      @(posedge clk); #1;
      check("w8_sign", out_data2, 16'hFF80);
      in_mode2 = 2'd2;
      @(posedge clk); #1;
      check("w8_upper", out_data2, 16'h8000);
      for (int c = 0; c < 60; c++) begin
         in_valid2  = 1'($urandom_range(0, 1));
         in_imm2    = 8'($urandom);
         in_mode2   = 2'($urandom);
         out_ready2 = ($urandom_range(0, 2) != 0);
         @(posedge clk); #1;
      end
      in_valid2 = 1'b0; out_ready2 = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      check("drain2_empty", q2.size(), 0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/imm_extend_pipe.md
# imm_extend_pipe

Parametrised, registered immediate-extension stage for the pipelined MIPS datapath. It sits between instruction decode and the ID/EX operand mux. It takes an `IN_W`-bit immediate plus a 2-bit mode and produces an `OUT_W`-bit operand. Transfers use a valid/ready handshake and the stage supports a synchronous pipeline flush. It generalises the plain 16→32 sign extender with zero-extend, upper-load and branch-offset modes.

## Interface
- `IN_W`, 16, immediate width; legal range 2..`OUT_W`-1
- `OUT_W`, 32, output operand width; `OUT_W` > `IN_W`
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  reset; asynchronous assert, active-low
- `flush`  in  1  synchronous pipeline flush
- `in_valid`  in  1  input beat valid
- `in_ready`  out  1  stage can accept a beat
- `in_imm`  in  `IN_W`  immediate field
- `in_mode`  in  2  extension mode, encoded as below
- `out_valid`  out  1  result valid
- `out_ready`  in  1  consumer accepts the result
- `out_data`  out  `OUT_W`  extended operand

The block has one clock. Reset is asynchronous and active-low.

## Operation
- Accept: an input beat transfers on a rising edge where `in_valid && in_ready`.
- Deliver: a result transfers on a rising edge where `out_valid && out_ready`.
- Mode functions, with `a = in_imm` and `E = OUT_W - IN_W`:
  - 0, sign: `{{E{a[IN_W-1]}}, a}`
  - 1, zero: `{{E{1'b0}}, a}`
  - 2, upper: `{a, {E{1'b0}}}`. With default widths this is `a<<16`, as for LUI.
  - 3, branch: the sign result shifted left by 2. The top 2 bits are discarded and the low 2 bits are 0.
- The mode is evaluated when the beat is accepted. The registered result is stored, not the mode.
- Ordering: results leave strictly in acceptance order. The stage never drops or duplicates a beat, except on `flush`.
- Flush:
  - On an edge with `flush=1`, all held beats are invalidated.
  - An input accepted on that same edge is discarded.
  - `out_data` keeps its last value. It is don't-care while `out_valid=0`.
- Reset values: `out_valid=0`, `out_data=0`, internal valid bits 0, `in_ready=1`.
- Reset mid-transfer: any held beat is lost immediately, asynchronously. No beat is presented after `rst_n` rises until a new accept occurs.

## Timing
- Latency: a beat accepted at edge N has `out_valid=1` with its result after edge N.
- Throughput: one beat per cycle while `out_ready=1`.
- Single-stage behaviour (macro off):
  - `in_ready = !out_valid || out_ready`. This is combinational from `out_ready`.
  - Simultaneous deliver and accept on one edge: the new result replaces the old and `out_valid` stays 1.
- Skid behaviour (macro on): two entries, main and skid.
  - States: EMPTY (none held), ONE (main held), FULL (main and skid held).
  - `in_ready` is a register: 1 in EMPTY and ONE, 0 in FULL.
  - EMPTY→ONE on accept.
  - ONE→EMPTY on deliver with no accept.
  - ONE→ONE on deliver with accept: main is replaced.
  - ONE→FULL on accept with no deliver: the beat goes into skid.
  - FULL→ONE on deliver: skid moves to main. No accept is possible in FULL.
  - Any state→EMPTY on `flush`.
- `out_valid`/`out_data` always reflect the main entry.
- `out_data` is stable while `out_valid && !out_ready`.

## Configuration
- `IMM_EXT_SKID_EN` defined: the two-entry skid buffer is built and `in_ready` is registered. There is no combinational path from `out_ready` to `in_ready`.
- Not defined: a single register stage with the combinational `in_ready` above. The function is identical at the handshake level; only the `in_ready` timing differs.

## Test plan
- Defaults, `out_ready=1`. Accept `in_imm=16'h8001` in modes 0, 1, 2, 3 on consecutive cycles → `out_data` is 32'hFFFF8001, 32'h00008001, 32'h80010000, 32'hFFFE0004 respectively, each 1 cycle after its accept, with `out_valid` held high.
- Positive value `16'h7FFF`, mode 0 → 32'h00007FFF; mode 3 → 32'h0001FFFC.
- Backpressure: hold `out_ready=0` while streaming 0x0001, 0x0002, 0x0003 in mode 1.
  - With the macro: `in_ready` drops after 2 accepts.
  - Without the macro: `in_ready` drops after 1 accept.
  - After releasing `out_ready`, the outputs appear in order with no loss or duplication.
- Flush in the FULL state, with a simultaneous `in_valid` → `out_valid=0` next cycle and the concurrent beat is never output.
- Pull `rst_n` low mid-cycle with a held beat → `out_valid=0` and `out_data=0` before the next clock edge, and `in_ready=1`.
- Parameter sweep `IN_W=8`, `OUT_W=16`: `8'h80` in mode 0 → 16'hFF80; in mode 2 → 16'h8000.
